spi_reg_responder: RTL and testbench
====================================

Name: spi_reg_responder

Overview:
- SPI mode-0 slave. It answers the SoC's spi0 master (MOSI/SCLK/SS_n out, MISO in) with a MAX3421E-style register file of 32 x 8-bit registers.
- Used as an on-FPGA peripheral and as a loop-back target for the SoC's USB/SPI driver path.
- Game logic reads and writes the same registers through a local port. An interrupt line is derived from selected registers.

Parameters:
- NREG, 32: number of 8-bit registers. Fixed at 32 because the address is 5 bits.
- STATUS_ADDR, 25: register shifted out on MISO during the command byte.
- IRQ_ADDR, 25: interrupt-flag register.
- IEN_ADDR, 26: interrupt-enable register.

Ports:
- Clk  in  1  system clock; must be at least 8x the SCLK frequency.
- Reset  in  1  asynchronous, active-high reset.
- spi_SCLK  in  1  SPI clock from the master (asynchronous).
- spi_MOSI  in  1  serial data from the master (asynchronous).
- spi_SS_n  in  1  slave select, active low (asynchronous).
- spi_MISO  out  1  serial data to the master.
- miso_oe  out  1  MISO drive enable; 1 while a transaction is active.
- loc_we  in  1  local write enable.
- loc_addr  in  5  local write/read address.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  register value at loc_addr, registered.
- wr_strobe  out  1  one-cycle pulse per committed SPI write.
- wr_addr  out  5  address of that SPI write.
- wr_data  out  8  data of that SPI write.
- int_n  out  1  low when (reg[IRQ_ADDR] & reg[IEN_ADDR]) != 0.

Behaviour:
- Input synchronisation and edge detection:
  - SCLK, MOSI and SS_n each pass through a 2-flop synchroniser.
  - A 3rd flop provides edge detection: sclk_rise, sclk_fall, ss_fall, ss_rise.
- Reset, asynchronous:
  - All registers = 0x00.
  - State = IDLE.
  - spi_MISO = 0, miso_oe = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, loc_rdata = 0, int_n = 1.
- FSM states: IDLE, CMD, DATA_WR, DATA_RD.
  - IDLE -> CMD on ss_fall. Actions: bit_cnt = 0; tx_shift = reg[STATUS_ADDR]; spi_MISO = its bit 7; miso_oe = 1.
  - On each sclk_rise: rx_shift = {rx_shift[6:0], MOSI}; bit_cnt++.
  - On each sclk_fall: tx_shift shifts left and spi_MISO = new bit 7, except on the fall that follows a byte boundary (below).
  - Byte boundary = the 8th sclk_rise (bit_cnt wraps 7 -> 0).
- CMD byte decode (MSB first):
  - bits[7:3] = register address, loaded into addr.
  - bit1 = direction: 1 = write -> DATA_WR; 0 = read -> DATA_RD.
  - bits 2 and 0 are ignored.
  - For a read, tx_shift is loaded with reg[addr]; its bit 7 is driven on the next sclk_fall.
- DATA_WR, at each byte boundary:
  - reg[addr] = received byte.
  - wr_strobe pulses for 1 cycle, with wr_addr = addr and wr_data = the byte.
  - addr = addr + 1 mod 32 (31 wraps to 0).
  - MISO shifts out 0x00 while writing.
- DATA_RD, at each byte boundary:
  - addr = addr + 1 mod 32; tx_shift = reg[new addr].
  - The first data byte returned is reg[cmd addr]; subsequent bytes are consecutive registers, with wrap.
- ss_rise, in any state:
  - Return to IDLE; miso_oe = 0; spi_MISO = 0.
  - A partial byte (bit_cnt != 0) is discarded: no write, no strobe.
- SCLK edges while in IDLE are ignored.
- Local port:
  - loc_we writes reg[loc_addr] = loc_wdata on the next edge.
  - loc_rdata = reg[loc_addr], with 1-cycle latency.
  - If a local write and an SPI commit hit the same address in the same cycle, the SPI value wins and the local write is dropped.
  - Writes to different addresses in the same cycle are both applied.
- Latencies:
  - An SPI commit is visible on loc_rdata 2 cycles after the synchronised 8th rise.
  - int_n is registered and updates 1 cycle after a register change.
- Timing requirement on the master: in mode 0 the first MISO bit is valid at most 4 Clk cycles after SS_n falls. The master must wait at least 4 Clk cycles before the first SCLK rise.

Test Plan:
- Reset check: assert Reset mid-transaction (SS_n low, 3 bits shifted) -> miso_oe=0, int_n=1, all registers read 0x00 via loc port; the next transaction decodes from bit 0.
- Burst write: SS_n low; send 0x0A (addr 1, write), 0x5A, 0xC3; SS_n high -> reg1=0x5A, reg2=0xC3; exactly two wr_strobe pulses, (1,0x5A) then (2,0xC3).
- Burst read: local-write reg25=0x42, reg3=0x81, reg4=0x7E; SPI send 0x18, 0x00, 0x00 -> MISO returns 0x42, 0x81, 0x7E; no wr_strobe.
- Wrap and abort:
  - Send 0xFA, 0x11, 0x22 -> reg31=0x11, reg0=0x22.
  - Then send 0x2A plus 5 data bits and raise SS_n -> reg5 unchanged, no strobe.
  - A following read of reg5 succeeds.
- Collision and interrupt:
  - Same cycle: loc_we to addr 26 with 0xFF, and an SPI commit of 0x01 to addr 26 -> reg26=0x01.
  - Then SPI-write reg25=0x01 -> int_n falls 1 cycle after the commit.
  - Local-write reg25=0x00 -> int_n returns high.

Source files
------------

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave exposing a 32 x 8-bit register file (MAX3421E-style command byte),
// with a local read/write port, per-write strobe and a level interrupt from IRQ & IEN.
module spi_reg_responder #(
    parameter int NREG        = 32,
    parameter int STATUS_ADDR = 25,
    parameter int IRQ_ADDR    = 25,
    parameter int IEN_ADDR    = 26
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       spi_SCLK,
    input  logic       spi_MOSI,
    input  logic       spi_SS_n,
    output logic       spi_MISO,
    output logic       miso_oe,
    input  logic       loc_we,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       int_n
);
    localparam logic [4:0] STATUS_IDX = 5'(STATUS_ADDR);
    localparam logic [4:0] IRQ_IDX    = 5'(IRQ_ADDR);
    localparam logic [4:0] IEN_IDX    = 5'(IEN_ADDR);

    typedef enum logic [1:0] {IDLE, CMD, DATA_WR, DATA_RD} state_t;

    logic [2:0] sclk_sync_reg;
    logic [2:0] ss_n_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [4:0] addr_reg, addr_next;
    logic       load_pend_reg, load_pend_next;
    logic       miso_reg, miso_next;
    logic       oe_reg, oe_next;
    logic       commit;
    logic [7:0] rx_byte;
    logic [4:0] addr_inc;

    logic [7:0]      reg_file [NREG];
    logic [NREG-1:0] spi_hit, loc_hit;

    logic       wr_strobe_reg;
    logic [4:0] wr_addr_reg;
    logic [7:0] wr_data_reg;
    logic [7:0] loc_rdata_reg;
    logic       int_n_reg;

    // Sync flops clear to 0 so a reset released while SS_n is already low
    // does not fake an ss_fall and join a frame halfway through.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sclk_sync_reg <= 3'b000;
            ss_n_sync_reg <= 3'b000;
            mosi_sync_reg <= 2'b00;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], spi_SCLK};
            ss_n_sync_reg <= {ss_n_sync_reg[1:0], spi_SS_n};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_MOSI};
        end
    end

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign ss_fall   = ~ss_n_sync_reg[1] & ss_n_sync_reg[2];
    assign ss_rise   = ss_n_sync_reg[1] & ~ss_n_sync_reg[2];
    assign mosi_s    = mosi_sync_reg[1];
    assign rx_byte   = {rx_shift_reg[6:0], mosi_s};
    assign addr_inc  = addr_reg + 5'd1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            rx_shift_reg  <= 8'h00;
            tx_shift_reg  <= 8'h00;
            addr_reg      <= 5'd0;
            load_pend_reg <= 1'b0;
            miso_reg      <= 1'b0;
            oe_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_shift_reg  <= rx_shift_next;
            tx_shift_reg  <= tx_shift_next;
            addr_reg      <= addr_next;
            load_pend_reg <= load_pend_next;
            miso_reg      <= miso_next;
            oe_reg        <= oe_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_shift_next  = rx_shift_reg;
        tx_shift_next  = tx_shift_reg;
        addr_next      = addr_reg;
        load_pend_next = load_pend_reg;
        miso_next      = miso_reg;
        oe_next        = oe_reg;
        commit         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next     = CMD;
                    bit_cnt_next   = 3'd0;
                    tx_shift_next  = reg_file[STATUS_IDX];
                    miso_next      = reg_file[STATUS_IDX][7];
                    oe_next        = 1'b1;
                    load_pend_next = 1'b0;
                end
            end
            default: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    oe_next    = 1'b0;
                    miso_next  = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_next = rx_byte;
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        // A freshly loaded byte is presented unshifted on the next fall.
                        load_pend_next = 1'b1;
                        case (state_reg)
                            CMD: begin
                                addr_next = rx_byte[7:3];
                                if (rx_byte[1]) begin
                                    state_next    = DATA_WR;
                                    tx_shift_next = 8'h00;
                                end else begin
                                    state_next    = DATA_RD;
                                    tx_shift_next = reg_file[rx_byte[7:3]];
                                end
                            end
                            DATA_WR: begin
                                commit        = 1'b1;
                                addr_next     = addr_inc;
                                tx_shift_next = 8'h00;
                            end
                            DATA_RD: begin
                                addr_next     = addr_inc;
                                tx_shift_next = reg_file[addr_inc];
                            end
                            default: ;
                        endcase
                    end
                end else if (sclk_fall) begin
                    if (load_pend_reg) begin
                        load_pend_next = 1'b0;
                        miso_next      = tx_shift_reg[7];
                    end else begin
                        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                        miso_next     = tx_shift_reg[6];
                    end
                end
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_hit
            assign spi_hit[gi] = commit && (addr_reg == 5'(gi));
            assign loc_hit[gi] = loc_we && (loc_addr == 5'(gi));
        end
    endgenerate

    // SPI commit takes priority over a local write to the same register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) reg_file[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (spi_hit[i])      reg_file[i] <= rx_byte;
                else if (loc_hit[i]) reg_file[i] <= loc_wdata;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 5'd0;
            wr_data_reg   <= 8'h00;
            loc_rdata_reg <= 8'h00;
            int_n_reg     <= 1'b1;
        end else begin
            wr_strobe_reg <= commit;
            if (commit) begin
                wr_addr_reg <= addr_reg;
                wr_data_reg <= rx_byte;
            end
            loc_rdata_reg <= reg_file[loc_addr];
            int_n_reg     <= ~|(reg_file[IRQ_IDX] & reg_file[IEN_IDX]);
        end
    end

    assign spi_MISO  = miso_reg;
    assign miso_oe   = oe_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign loc_rdata = loc_rdata_reg;
    assign int_n     = int_n_reg;
endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: directed vector table, hand-built corner sequences and
// random bursts checked against a register-array reference model.
module tb_spi_reg_responder;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       spi_SCLK = 1'b0;
    logic       spi_MOSI = 1'b0;
    logic       spi_SS_n = 1'b1;
    logic       spi_MISO;
    logic       miso_oe;
    logic       loc_we = 1'b0;
    logic [4:0] loc_addr = 5'd0;
    logic [7:0] loc_wdata = 8'h00;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       int_n;

    spi_reg_responder dut (
        .Clk(Clk), .Reset(Reset),
        .spi_SCLK(spi_SCLK), .spi_MOSI(spi_MOSI), .spi_SS_n(spi_SS_n),
        .spi_MISO(spi_MISO), .miso_oe(miso_oe),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .int_n(int_n)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  model [32];
    logic [12:0] got_q [$];
    logic [12:0] exp_q [$];

    always @(negedge Clk) if (wr_strobe) got_q.push_back({wr_addr, wr_data});

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_MOSI = b;
        repeat (6) @(negedge Clk);
        spi_SCLK = 1'b1;
        r = spi_MISO;
        repeat (6) @(negedge Clk);
        spi_SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic ss_low();
        @(negedge Clk);
        spi_SS_n = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic ss_high();
        repeat (6) @(negedge Clk);
        spi_SS_n = 1'b1;
        repeat (6) @(negedge Clk);
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge Clk);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge Clk);
        loc_we = 1'b0;
        model[a] = d;
    endtask

    task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge Clk);
        loc_addr = a;
        @(negedge Clk);
        d = loc_rdata;
    endtask

    task automatic check_strobes(input string name);
        check({name, "_strobe_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({name, "_strobe"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    // Model: status byte first, then writes land consecutively (MISO idles at 0)
    // or reads return consecutive registers, addresses wrapping mod 32.
    task automatic txn(input logic [7:0] cmd, input logic [7:0] data [4], input int n,
                       output logic [7:0] got [5], output logic [7:0] exp [5]);
        logic [4:0] a;
        logic [7:0] r;
        for (int i = 0; i < 5; i++) begin got[i] = 8'h00; exp[i] = 8'h00; end
        exp[0] = model[25];
        a = cmd[7:3];
        for (int i = 0; i < n; i++) begin
            if (cmd[1]) begin
                model[a] = data[i];
                exp_q.push_back({a, data[i]});
            end else begin
                exp[i+1] = model[a];
            end
            a = a + 5'd1;
        end
        ss_low();
        spi_byte(cmd, r);
        got[0] = r;
        for (int i = 0; i < n; i++) begin
            spi_byte(data[i], r);
            got[i+1] = r;
        end
        ss_high();
        check_strobes("txn");
        $display("txn cmd=%02h n=%0d miso=%02h %02h %02h %02h %02h", cmd, n,
                 got[0], got[1], got[2], got[3], got[4]);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0, d1;
        logic [7:0] m0, m1, m2;
        logic [4:0] ca0;
        logic [7:0] cv0;
        logic [4:0] ca1;
        logic [7:0] cv1;
        int         nstb;
    } vec_t;

    initial begin
        vec_t       vecs [4];
        logic [7:0] data [4];
        logic [7:0] got [5];
        logic [7:0] exp [5];
        logic [7:0] rd;
        logic       r;
        int         k;
        int         n;

        vecs[0] = '{8'h0A, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 5'd1,  8'h5A, 5'd2, 8'hC3, 2};
        vecs[1] = '{8'hFA, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 5'd31, 8'h11, 5'd0, 8'h22, 2};
        vecs[2] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3, 5'd1,  8'h5A, 5'd2, 8'hC3, 0};
        vecs[3] = '{8'hF8, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 5'd31, 8'h11, 5'd0, 8'h22, 0};
        for (int i = 0; i < 32; i++) model[i] = 8'h00;

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_miso", spi_MISO, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_int_n", int_n, 1);
        check("rst_loc_rdata", loc_rdata, 8'h00);

        for (int v = 0; v < 4; v++) begin
            data = '{vecs[v].d0, vecs[v].d1, 8'h00, 8'h00};
            exp_q.delete();
            if (vecs[v].nstb == 2) begin
                check("vec_pre_strobes", got_q.size(), 0);
            end
            txn(vecs[v].cmd, data, 2, got, exp);
            check("vec_miso0", got[0], vecs[v].m0);
            check("vec_miso1", got[1], vecs[v].m1);
            check("vec_miso2", got[2], vecs[v].m2);
            loc_read(vecs[v].ca0, rd);
            check("vec_reg_a", rd, vecs[v].cv0);
            loc_read(vecs[v].ca1, rd);
            check("vec_reg_b", rd, vecs[v].cv1);
        end

        // Burst read with status byte
        loc_write(5'd25, 8'h42);
        loc_write(5'd3, 8'h81);
        loc_write(5'd4, 8'h7E);
        data = '{8'h00, 8'h00, 8'h00, 8'h00};
        txn(8'h18, data, 2, got, exp);
        check("rd_status", got[0], 8'h42);
        check("rd_byte1", got[1], 8'h81);
        check("rd_byte2", got[2], 8'h7E);

        // Aborted write: partial byte must be discarded
        loc_write(5'd5, 8'h99);
        ss_low();
        spi_byte(8'h2A, rd);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
        ss_high();
        check("abort_strobes", got_q.size(), 0);
        got_q.delete();
        loc_read(5'd5, rd);
        check("abort_reg5", rd, 8'h99);
        txn(8'h28, data, 1, got, exp);
        check("abort_read_status", got[0], 8'h42);
        check("abort_read_reg5", got[1], 8'h99);
        $display("txn abort cmd=2a partial=5 bits");

        // Collision: local write and SPI commit on reg26 in the same cycle
        ss_low();
        spi_byte(8'hD2, rd);
        for (int i = 0; i < 7; i++) spi_bit(1'b0, r);
        spi_MOSI = 1'b1;
        repeat (6) @(negedge Clk);
        spi_SCLK = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        loc_we = 1'b1; loc_addr = 5'd26; loc_wdata = 8'hFF;
        @(negedge Clk);
        loc_we = 1'b0;
        check("collide_aligned", wr_strobe, 1);
        repeat (5) @(negedge Clk);
        spi_SCLK = 1'b0;
        ss_high();
        model[26] = 8'h01;
        exp_q.push_back({5'd26, 8'h01});
        check_strobes("collide");
        loc_read(5'd26, rd);
        check("collide_reg26", rd, 8'h01);
        $display("txn collide cmd=d2 data=01 local=ff");

        // Interrupt: SPI write reg25=0x01 with IEN=0x01
        ss_low();
        spi_byte(8'hCA, rd);
        for (int i = 0; i < 7; i++) spi_bit(1'b0, r);
        spi_MOSI = 1'b1;
        repeat (6) @(negedge Clk);
        spi_SCLK = 1'b1;
        k = 0;
        while (!wr_strobe && k < 10) begin
            @(negedge Clk);
            k++;
        end
        check("int_strobe_seen", wr_strobe, 1);
        check("int_n_at_commit", int_n, 1);
        @(negedge Clk);
        check("int_n_after_commit", int_n, 0);
        repeat (4) @(negedge Clk);
        spi_SCLK = 1'b0;
        ss_high();
        model[25] = 8'h01;
        exp_q.push_back({5'd25, 8'h01});
        check_strobes("int");
        $display("txn int cmd=ca data=01");
        loc_write(5'd25, 8'h00);
        repeat (2) @(negedge Clk);
        check("int_n_cleared", int_n, 1);
        loc_write(5'd25, 8'h01);
        repeat (2) @(negedge Clk);
        check("int_n_reasserted", int_n, 0);

        // Reset mid-transaction
        ss_low();
        spi_bit(1'b1, r);
        spi_bit(1'b0, r);
        spi_bit(1'b1, r);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("midrst_miso_oe", miso_oe, 0);
        check("midrst_miso", spi_MISO, 0);
        check("midrst_int_n", int_n, 1);
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        got_q.delete();
        repeat (3) @(negedge Clk);
        check("midrst_oe_after", miso_oe, 0);
        for (int i = 0; i < 32; i++) begin
            loc_read(5'(i), rd);
            check("midrst_reg", {24'd0, rd} | (i << 8), i << 8);
        end
        spi_SS_n = 1'b1;
        repeat (6) @(negedge Clk);
        data = '{8'hA5, 8'h00, 8'h00, 8'h00};
        txn(8'h3A, data, 1, got, exp);
        check("post_rst_status", got[0], 8'h00);
        loc_read(5'd7, rd);
        check("post_rst_reg7", rd, 8'hA5);

        // Random bursts against the model
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
            txn(8'($urandom), data, n, got, exp);
            for (int i = 0; i <= n; i++) check("rand_miso", got[i], exp[i]);
        end
        for (int i = 0; i < 32; i++) begin
            loc_read(5'(i), rd);
            check("rand_reg", rd, model[i]);
        end
        repeat (2) @(negedge Clk);
        check("rand_int_n", int_n, ~|(model[25] & model[26]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
